// File: rtl/idli_sqi_resp_m.sv
// SQI memory responder: command 0x03 reads / 0x02 writes a byte store via a 24-bit address.
// Defining IDLI_SQI_RESP_BKDR_EN adds a backdoor write port into the store.
module idli_sqi_resp_m #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        i_resp_gck,
    input  logic        i_resp_rst,
    input  logic        i_resp_sck,
    input  logic        i_resp_cs,
    input  logic [3:0]  i_resp_sio,
`ifdef IDLI_SQI_RESP_BKDR_EN
    input  logic        i_resp_bd_wr,
    input  logic [15:0] i_resp_bd_addr,
    input  logic [7:0]  i_resp_bd_data,
`endif
    output logic [3:0]  o_resp_sio,
    output logic        o_resp_sio_oe
);
    localparam int unsigned AW = (MEM_BYTES > 32'd1) ? $clog2(MEM_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DUMMY  = 3'd3,
        RDATA  = 3'd4,
        WDATA  = 3'd5,
        IGNORE = 3'd6
    } state_t;

    state_t        state_q;
    logic          sck_q;
    logic [2:0]    cnt_q;
    logic [19:0]   shift_q;
    logic [AW-1:0] addr_q;
    logic          rd_q;
    logic          wait_cs_q;
    logic [3:0]    sio_q;
    logic          oe_q;
    logic [7:0]    mem_q [MEM_BYTES];

    logic          rise_s;
    logic          fall_s;
    logic          wr_en_s;
    logic [7:0]    cmd_s;
    logic [7:0]    wr_byte_s;
    logic [7:0]    rd_byte_s;
    logic [23:0]   addr_full_s;
    logic [AW-1:0] addr_inc_d;
    logic          unused_s;

    assign rise_s      = i_resp_sck & ~sck_q;
    assign fall_s      = ~i_resp_sck & sck_q;
    assign cmd_s       = {shift_q[3:0], i_resp_sio};
    assign wr_byte_s   = {shift_q[3:0], i_resp_sio};
    assign addr_full_s = {shift_q, i_resp_sio};
    assign rd_byte_s   = mem_q[addr_q];
    assign addr_inc_d  = addr_q + AW'(1);
    assign wr_en_s     = (state_q == WDATA) && !i_resp_cs && rise_s && (cnt_q == 3'd1);

`ifdef IDLI_SQI_RESP_BKDR_EN
    assign unused_s = ^{addr_full_s, i_resp_bd_addr};
`else
    assign unused_s = ^addr_full_s;
`endif

    // Protocol FSM; wait_cs_q blocks a new command after reset until CS has been released once.
    always_ff @(posedge i_resp_gck or posedge i_resp_rst) begin
        if (i_resp_rst) begin
            state_q   <= IDLE;
            sck_q     <= 1'b0;
            cnt_q     <= 3'd0;
            shift_q   <= 20'd0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wait_cs_q <= 1'b1;
            sio_q     <= 4'h0;
            oe_q      <= 1'b0;
        end else begin
            sck_q <= i_resp_sck;
            if (i_resp_cs) begin
                state_q   <= IDLE;
                cnt_q     <= 3'd0;
                shift_q   <= 20'd0;
                wait_cs_q <= 1'b0;
                sio_q     <= 4'h0;
                oe_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!wait_cs_q) begin
                            state_q <= CMD;
                            cnt_q   <= 3'd0;
                        end
                    end
                    CMD: begin
                        if (rise_s) begin
                            shift_q <= {shift_q[15:0], i_resp_sio};
                            if (cnt_q == 3'd1) begin
                                cnt_q <= 3'd0;
                                case (cmd_s)
                                    8'h03: begin state_q <= ADDR; rd_q <= 1'b1; end
                                    8'h02: begin state_q <= ADDR; rd_q <= 1'b0; end
                                    default: state_q <= IGNORE;
                                endcase
                            end else begin
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rise_s) begin
                            shift_q <= {shift_q[15:0], i_resp_sio};
                            if (cnt_q == 3'd5) begin
                                cnt_q   <= 3'd0;
                                addr_q  <= addr_full_s[AW-1:0];
                                state_q <= rd_q ? DUMMY : WDATA;
                            end else begin
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (rise_s) begin
                            if (cnt_q == 3'd1) begin
                                cnt_q   <= 3'd0;
                                state_q <= RDATA;
                            end else begin
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end
                    end
                    RDATA: begin
                        if (fall_s) begin
                            oe_q <= 1'b1;
                            if (cnt_q == 3'd0) begin
                                sio_q <= rd_byte_s[7:4];
                                cnt_q <= 3'd1;
                            end else begin
                                sio_q  <= rd_byte_s[3:0];
                                addr_q <= addr_inc_d;
                                cnt_q  <= 3'd0;
                            end
                        end
                    end
                    WDATA: begin
                        if (rise_s) begin
                            shift_q <= {shift_q[15:0], i_resp_sio};
                            if (cnt_q == 3'd1) begin
                                addr_q <= addr_inc_d;
                                cnt_q  <= 3'd0;
                            end else begin
                                cnt_q <= 3'd1;
                            end
                        end
                    end
                    IGNORE: state_q <= IGNORE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Byte store; the backdoor write comes last so it overrides a same-address SQI write.
    always_ff @(posedge i_resp_gck) begin
        if (wr_en_s) begin
            mem_q[addr_q] <= wr_byte_s;
        end
`ifdef IDLI_SQI_RESP_BKDR_EN
        if (i_resp_bd_wr) begin
            mem_q[i_resp_bd_addr[AW-1:0]] <= i_resp_bd_data;
        end
`endif
    end

    assign o_resp_sio    = sio_q;
    assign o_resp_sio_oe = oe_q;

endmodule
